sync_fifo_param: RTL



---
 rtl/sync_fifo_param_if.sv | 31 +++
 rtl/sync_fifo_param.sv | 95 +++++++++
 2 files changed

// File: rtl/sync_fifo_param_if.sv
// sync_fifo_param_if: producer/consumer handshake and status bundle for sync_fifo_param
interface sync_fifo_param_if #(
    parameter int DATA_W = 4,
    parameter int ADDR_W = 3
);
    logic              i_wen;
    logic              i_ren;
    logic              i_clr_err;
    logic [DATA_W-1:0] data_in;
    logic [DATA_W-1:0] data_out;
    logic              rd_valid;
    logic              full_flag;
    logic              empty_flag;
    logic              almost_full;
    logic              almost_empty;
    logic [ADDR_W:0]   count;
    logic              overflow_flag;
    logic              underflow_flag;

    modport master (
        output i_wen, i_ren, i_clr_err, data_in,
        input  data_out, rd_valid, full_flag, empty_flag, almost_full, almost_empty,
               count, overflow_flag, underflow_flag
    );

    modport slave (
        input  i_wen, i_ren, i_clr_err, data_in,
        output data_out, rd_valid, full_flag, empty_flag, almost_full, almost_empty,
               count, overflow_flag, underflow_flag
    );
endinterface

// File: rtl/sync_fifo_param.sv
// sync_fifo_param: single-clock FIFO with occupancy, almost thresholds and read-valid strobe.
// Define FIFO_ERR_FLAGS_EN to build the sticky overflow/underflow flags; otherwise they read 0.
module sync_fifo_param #(
    parameter int DATA_W = 4,
    parameter int ADDR_W = 3,
    parameter int AF_TH  = 6,
    parameter int AE_TH  = 2
) (
    input logic               i_clk,
    input logic               i_rst,
    sync_fifo_param_if.slave  bus
);
    localparam int DEPTH = 1 << ADDR_W;
    localparam logic [ADDR_W:0] DEPTH_C = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [ADDR_W:0] AF_C = (ADDR_W+1)'(AF_TH);
    localparam logic [ADDR_W:0] AE_C = (ADDR_W+1)'(AE_TH);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [ADDR_W:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, count_q, count_d;
    logic [DATA_W-1:0] dout_q, dout_d;
    logic              rd_valid_q, rd_valid_d;
    logic              full_q, full_d, empty_q, empty_d, af_q, af_d, ae_q, ae_d;
    logic              ovf_q, ovf_d, unf_q, unf_d;
    logic              wr_acc, rd_acc;

    // Acceptance looks only at the registered flags, so a full FIFO refuses writes even alongside a read
    always_comb begin
        wr_acc     = bus.i_wen && !full_q;
        rd_acc     = bus.i_ren && !empty_q;
        wr_ptr_d   = wr_acc ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d   = rd_acc ? rd_ptr_q + 1'b1 : rd_ptr_q;
        count_d    = (wr_acc && !rd_acc) ? count_q + 1'b1 :
                     (rd_acc && !wr_acc) ? count_q - 1'b1 : count_q;
        dout_d     = rd_acc ? mem_q[rd_ptr_q[ADDR_W-1:0]] : dout_q;
        rd_valid_d = rd_acc;
        full_d     = count_d == DEPTH_C;
        empty_d    = count_d == '0;
        af_d       = count_d >= AF_C;
        ae_d       = count_d <= AE_C;
`ifdef FIFO_ERR_FLAGS_EN
        ovf_d      = (bus.i_wen && full_q) || (ovf_q && !bus.i_clr_err);
        unf_d      = (bus.i_ren && empty_q) || (unf_q && !bus.i_clr_err);
`else
        ovf_d      = 1'b0;
        unf_d      = 1'b0;
`endif
    end

`ifndef FIFO_ERR_FLAGS_EN
    logic unused_clr_err;
    assign unused_clr_err = bus.i_clr_err;
`endif

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            dout_q     <= '0;
            rd_valid_q <= 1'b0;
            full_q     <= 1'b0;
            empty_q    <= 1'b1;
            af_q       <= AF_TH == 0;
            ae_q       <= 1'b1;
            ovf_q      <= 1'b0;
            unf_q      <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            dout_q     <= dout_d;
            rd_valid_q <= rd_valid_d;
            full_q     <= full_d;
            empty_q    <= empty_d;
            af_q       <= af_d;
            ae_q       <= ae_d;
            ovf_q      <= ovf_d;
            unf_q      <= unf_d;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst && wr_acc) mem_q[wr_ptr_q[ADDR_W-1:0]] <= bus.data_in;
    end

    assign bus.data_out       = dout_q;
    assign bus.rd_valid       = rd_valid_q;
    assign bus.full_flag      = full_q;
    assign bus.empty_flag     = empty_q;
    assign bus.almost_full    = af_q;
    assign bus.almost_empty   = ae_q;
    assign bus.count          = count_q;
    assign bus.overflow_flag  = ovf_q;
    assign bus.underflow_flag = unf_q;
endmodule
